aes128_cbc_ctrl: RTL and testbench

- CBC-mode sequencer wrapped around the aes128 core. It is both the core's upstream feeder and its downstream consumer.
- Accepts key/IV configuration and a 128-bit block stream over valid/ready.
- Drives the core's single shared input lane and its reset_key / load_data pulses, then chains ciphertext.
- Presents one result block per input block on a valid/ready output.

---
 rtl/aes128_cbc_ctrl.sv | 94 +++++++++
 tb/tb_aes128_cbc_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/aes128_cbc_ctrl.sv
// aes128_cbc_ctrl: CBC-mode sequencer that feeds an aes128 core and chains its results
module aes128_cbc_ctrl #(
  parameter int WAIT_TIMEOUT = 32,
  parameter int TMR_W = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cfg_start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] iv_i,
  input  logic         cfg_enc_i,
  input  logic [127:0] s_data_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  output logic [127:0] m_data_o,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [127:0] core_lane_o,
  output logic         core_reset_key_o,
  output logic         core_load_data_o,
  output logic         core_enc_or_dec_o,
  input  logic [127:0] core_text_i,
  input  logic         core_cipher_ready_i,
  input  logic         core_key_ready_i,
  output logic         key_valid_o,
  output logic         busy_o,
  output logic         error_o
);
  typedef enum logic [2:0] {IDLE, KEY_LOAD, KEY_WAIT, READY, BLK_LOAD, BLK_WAIT, OUT_HOLD, ERROR} state_t;
  state_t state, state_n;
  logic [127:0] chain, in_reg, lane, out_r;
  logic mode;
  logic [TMR_W-1:0] tmr;
  logic cfg_acc, blk_acc, past_guard, timed_out, cap;
  assign cfg_acc = cfg_start_i & (state == IDLE | state == READY | state == ERROR);
  assign s_ready_o = (state == READY) & ~cfg_start_i;
  assign blk_acc = s_valid_i & s_ready_o;
  assign past_guard = tmr != '0;
  assign timed_out = tmr == TMR_W'(WAIT_TIMEOUT - 1);
  assign cap = (state == BLK_WAIT) & past_guard & core_cipher_ready_i;
  assign m_data_o = out_r;
  assign m_valid_o = state == OUT_HOLD;
  assign core_lane_o = lane;
  assign core_reset_key_o = state == KEY_LOAD;
  assign core_load_data_o = state == BLK_LOAD;
  assign core_enc_or_dec_o = mode;
  assign key_valid_o = state == READY | state == BLK_LOAD | state == BLK_WAIT | state == OUT_HOLD;
  assign busy_o = ~(state == IDLE | state == READY | state == ERROR);
  assign error_o = state == ERROR;
  // state register
  always_ff @(posedge clk_i)
    state <= rst_i ? IDLE : state_n;
  // next-state: one block in flight, guarded waits with timeout
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = cfg_acc ? KEY_LOAD : IDLE;
      KEY_LOAD: state_n = KEY_WAIT;
      KEY_WAIT: state_n = (past_guard & core_key_ready_i) ? READY : timed_out ? ERROR : KEY_WAIT;
      READY:    state_n = cfg_acc ? KEY_LOAD : blk_acc ? BLK_LOAD : READY;
      BLK_LOAD: state_n = BLK_WAIT;
      BLK_WAIT: state_n = cap ? OUT_HOLD : timed_out ? ERROR : BLK_WAIT;
      OUT_HOLD: state_n = m_ready_i ? READY : OUT_HOLD;
      ERROR:    state_n = cfg_acc ? KEY_LOAD : ERROR;
      default:  state_n = IDLE;
    endcase
  end
  // datapath: config latch, lane preparation, CBC chaining and wait timer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain <= '0;
      in_reg <= '0;
      lane <= '0;
      out_r <= '0;
      mode <= 1'b0;
      tmr <= '0;
    end else begin
      tmr <= (state == KEY_WAIT || state == BLK_WAIT) ? tmr + 1'b1 : '0;
      if (cfg_acc) begin
        lane <= key_i;
        chain <= iv_i;
        mode <= cfg_enc_i;
      end
      if (blk_acc) begin
        in_reg <= s_data_i;
        lane <= mode ? s_data_i ^ chain : s_data_i;
      end
      if (cap) begin
        out_r <= mode ? core_text_i : core_text_i ^ chain;
        chain <= mode ? core_text_i : in_reg;
      end
    end
  end
endmodule

// File: tb/tb_aes128_cbc_ctrl.sv
// tb_aes128_cbc_ctrl: directed CBC vectors against a table-lookup stand-in for the aes128 core
module tb_aes128_cbc_ctrl;
  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;
  logic clk_i = 0, rst_i = 1, cfg_start_i = 0, cfg_enc_i = 0, s_valid_i = 0, m_ready_i = 0;
  logic [127:0] key_i = '0, iv_i = '0, s_data_i = '0;
  logic s_ready_o, m_valid_o, core_reset_key_o, core_load_data_o, core_enc_or_dec_o;
  logic key_valid_o, busy_o, error_o;
  logic [127:0] m_data_o, core_lane_o;
  logic [127:0] core_text_i = '0;
  logic core_cipher_ready_i = 0, core_key_ready_i = 0;
  int checks = 0, errors = 0;
  int n_rk = 0, n_ld = 0, n_overlap = 0;
  int kcnt = 0, ccnt = 0;
  logic stuck = 0;
  logic [127:0] c_in = '0;
  logic c_mode = 0;
  logic tab_mode [4];
  logic [127:0] tab_in [4];
  logic [127:0] tab_out [4];
  typedef struct {logic enc; logic [127:0] din; logic [127:0] exp; int hold;} vec_t;
  vec_t vecs [4];
  aes128_cbc_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_start_i(cfg_start_i), .key_i(key_i), .iv_i(iv_i),
    .cfg_enc_i(cfg_enc_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .core_lane_o(core_lane_o),
    .core_reset_key_o(core_reset_key_o), .core_load_data_o(core_load_data_o),
    .core_enc_or_dec_o(core_enc_or_dec_o), .core_text_i(core_text_i),
    .core_cipher_ready_i(core_cipher_ready_i), .core_key_ready_i(core_key_ready_i),
    .key_valid_o(key_valid_o), .busy_o(busy_o), .error_o(error_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [127:0] core_fn(input logic m, input logic [127:0] x);
    core_fn = ~x;
    for (int i = 0; i < 4; i++)
      if (tab_mode[i] == m && tab_in[i] == x) core_fn = tab_out[i];
  endfunction
  // core stand-in: fixed 10-cycle key schedule and block latency, ready dropped on each new pulse
  always @(posedge clk_i) begin
    if (core_reset_key_o) begin
      core_key_ready_i <= 0;
      kcnt <= 10;
    end else if (kcnt != 0) begin
      kcnt <= kcnt - 1;
      if (kcnt == 1) core_key_ready_i <= 1;
    end
    if (core_load_data_o) begin
      core_cipher_ready_i <= 0;
      ccnt <= 10;
      c_in <= core_lane_o;
      c_mode <= core_enc_or_dec_o;
    end else if (ccnt != 0) begin
      ccnt <= ccnt - 1;
      if (ccnt == 1 && !stuck) begin
        core_cipher_ready_i <= 1;
        core_text_i <= core_fn(c_mode, c_in);
      end
    end
  end
  // pulse monitor: counts core pulses and any cycle where both are high
  always @(posedge clk_i) begin
    if (core_reset_key_o) n_rk <= n_rk + 1;
    if (core_load_data_o) n_ld <= n_ld + 1;
    if (core_reset_key_o && core_load_data_o) n_overlap <= n_overlap + 1;
  end
  task automatic tick;
    @(negedge clk_i);
  endtask
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic configure(input logic enc);
    int rk0;
    rk0 = n_rk;
    cfg_start_i = 1; key_i = KEY; iv_i = IV; cfg_enc_i = enc;
    tick;
    cfg_start_i = 0;
    for (int n = 0; n < 100 && !key_valid_o; n++) tick;
    chki("cfg_key_valid", int'(key_valid_o), 1);
    chki("cfg_reset_key_pulses", n_rk - rk0, 1);
    chki("cfg_s_ready", int'(s_ready_o), 1);
    chki("cfg_error", int'(error_o), 0);
    chki("cfg_mode", int'(core_enc_or_dec_o), int'(enc));
  endtask
  task automatic send_block(input logic [127:0] d, input logic [127:0] e, input int hold);
    int ld0;
    for (int n = 0; n < 100 && !s_ready_o; n++) tick;
    chki("blk_s_ready", int'(s_ready_o), 1);
    s_valid_i = 1; s_data_i = d;
    tick;
    s_valid_i = 0;
    for (int n = 0; n < 100 && !m_valid_o; n++) tick;
    chki("blk_m_valid", int'(m_valid_o), 1);
    chk("blk_m_data", m_data_o, e);
    ld0 = n_ld;
    for (int h = 0; h < hold; h++) begin
      tick;
      chk("hold_m_data", m_data_o, e);
      chki("hold_s_ready", int'(s_ready_o), 0);
      chki("hold_m_valid", int'(m_valid_o), 1);
    end
    if (hold > 0) chki("hold_no_load", n_ld - ld0, 0);
    m_ready_i = 1;
    tick;
    m_ready_i = 0;
    chki("blk_released", int'(m_valid_o), 0);
  endtask
  initial begin
    int n, rk0, ld0;
    logic seen;
    tab_mode[0] = 1; tab_in[0] = P1 ^ IV; tab_out[0] = C1;
    tab_mode[1] = 1; tab_in[1] = P2 ^ C1; tab_out[1] = C2;
    tab_mode[2] = 0; tab_in[2] = C1;      tab_out[2] = P1 ^ IV;
    tab_mode[3] = 0; tab_in[3] = C2;      tab_out[3] = P2 ^ C1;
    vecs[0] = '{1, P1, C1, 0};
    vecs[1] = '{1, P2, C2, 20};
    vecs[2] = '{0, C1, P1, 0};
    vecs[3] = '{0, C2, P2, 0};
    tick; tick;
    chki("rst_m_valid", int'(m_valid_o), 0);
    chki("rst_s_ready", int'(s_ready_o), 0);
    chki("rst_key_valid", int'(key_valid_o), 0);
    chki("rst_busy", int'(busy_o), 0);
    chki("rst_error", int'(error_o), 0);
    chki("rst_pulses", int'({core_reset_key_o, core_load_data_o, core_enc_or_dec_o}), 0);
    chk("rst_m_data", m_data_o, '0);
    chk("rst_lane", core_lane_o, '0);
    rst_i = 0;
    tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 0 || vecs[i].enc != vecs[i-1].enc) configure(vecs[i].enc);
      send_block(vecs[i].din, vecs[i].exp, vecs[i].hold);
    end
    configure(1);
    stuck = 1;
    s_valid_i = 1; s_data_i = P1;
    tick;
    s_valid_i = 0;
    n = 0;
    while (!error_o && n < 100) begin
      tick;
      n++;
    end
    chki("timeout_cycles", n, 33);
    chki("timeout_key_valid", int'(key_valid_o), 0);
    chki("timeout_m_valid", int'(m_valid_o), 0);
    chki("timeout_busy", int'(busy_o), 0);
    stuck = 0;
    repeat (3) tick;
    chki("error_sticky", int'(error_o), 1);
    configure(1);
    send_block(P1, C1, 0);
    send_block(P2, C2, 0);
    s_valid_i = 1; s_data_i = P1;
    tick;
    s_valid_i = 0;
    repeat (4) tick;
    chki("midrst_busy_before", int'(busy_o), 1);
    rst_i = 1;
    tick;
    rst_i = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      seen |= m_valid_o;
      tick;
    end
    chki("midrst_no_m_valid", int'(seen), 0);
    chki("midrst_s_ready", int'(s_ready_o), 0);
    chki("midrst_idle", int'(busy_o), 0);
    chki("midrst_key_valid", int'(key_valid_o), 0);
    configure(1);
    rk0 = n_rk; ld0 = n_ld;
    cfg_start_i = 1; key_i = KEY; iv_i = IV; cfg_enc_i = 1;
    s_valid_i = 1; s_data_i = P2;
    #1;
    chki("collide_s_ready", int'(s_ready_o), 0);
    tick;
    cfg_start_i = 0; s_valid_i = 0;
    for (int i = 0; i < 100 && !key_valid_o; i++) tick;
    chki("collide_key_valid", int'(key_valid_o), 1);
    chki("collide_reload", n_rk - rk0, 1);
    chki("collide_no_load", n_ld - ld0, 0);
    send_block(P1, C1, 0);
    chki("pulse_overlap", n_overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
